// File: rtl/seq_table_loader_if.sv
// seq_table_loader_if: control, prescale, stream and sequencer-write signals
// of the table loader. slave = the loader, master = whoever drives it.
interface seq_table_loader_if;
    logic        load_start_i;
    logic [15:0] load_lines_i;
    logic        abort_i;
    logic [31:0] prescale_i;
    logic        prescale_wstb_i;
    logic [31:0] s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic        seq_active_i;
    logic        TABLE_START_o;
    logic [31:0] TABLE_DATA_o;
    logic        TABLE_WSTB_o;
    logic [15:0] TABLE_LENGTH_o;
    logic        TABLE_LENGTH_WSTB_o;
    logic [31:0] PRESCALE_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;

    modport slave (
        input  load_start_i, load_lines_i, abort_i, prescale_i, prescale_wstb_i,
        input  s_data_i, s_valid_i, seq_active_i,
        output s_ready_o, TABLE_START_o, TABLE_DATA_o, TABLE_WSTB_o,
        output TABLE_LENGTH_o, TABLE_LENGTH_WSTB_o, PRESCALE_o, busy_o, done_o, err_o
    );

    modport master (
        output load_start_i, load_lines_i, abort_i, prescale_i, prescale_wstb_i,
        output s_data_i, s_valid_i, seq_active_i,
        input  s_ready_o, TABLE_START_o, TABLE_DATA_o, TABLE_WSTB_o,
        input  TABLE_LENGTH_o, TABLE_LENGTH_WSTB_o, PRESCALE_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/seq_table_loader.sv
// seq_table_loader: frames a valid/ready word stream into sequencer table
// writes (start strobe, data strobes, length commit) and latches PRESCALE
// at table start. Define SEQ_LOADER_TIMEOUT_EN to compile in a STREAM stall
// timeout of TIMEOUT_CYCLES idle clocks that behaves like abort_i.
module seq_table_loader #(
    parameter int WORDS_PER_LINE = 4,
    parameter int MAX_LINES      = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic               clk_i,
    input logic               reset_n_i,
    seq_table_loader_if.slave bus
);
    localparam logic [16:0] MAX_LINES_W = 17'(MAX_LINES);
    localparam logic [15:0] WPL_W       = 16'(WORDS_PER_LINE);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_STREAM, ST_COMMIT, ST_DONE} state_t;

    state_t      state_reg;
    logic [15:0] target_reg;
    logic [15:0] count_reg;
    logic [15:0] table_length_reg;
    logic [31:0] shadow_reg;
    logic [31:0] prescale_reg;
    logic [31:0] table_data_reg;
    logic        table_start_reg;
    logic        table_wstb_reg;
    logic        table_length_wstb_reg;
    logic        s_ready_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [1:0]  err_reg;

    logic        lines_ok;
    logic [15:0] target_next;
    logic        accept;
    logic        in_load;
    logic        timeout_hit;
    logic        abort_now;

`ifdef SEQ_LOADER_TIMEOUT_EN
    localparam logic [31:0] STALL_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] stall_reg;

    // Stall counter: idle STREAM clocks since the last accepted word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_reg <= '0;
        end else if (state_reg != ST_STREAM || accept) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign timeout_hit = (state_reg == ST_STREAM) && !accept && (stall_reg == STALL_LIMIT);
`else
    // Without the stall counter TIMEOUT_CYCLES has no meaning.
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // Request decode: length legality, word target, handshake and abort.
    always_comb begin
        lines_ok    = (bus.load_lines_i != 16'd0) && ({1'b0, bus.load_lines_i} <= MAX_LINES_W);
        target_next = bus.load_lines_i * WPL_W;
        accept      = bus.s_valid_i && s_ready_reg;
        in_load     = (state_reg == ST_START) || (state_reg == ST_STREAM) ||
                      (state_reg == ST_COMMIT);
        abort_now   = in_load && (bus.abort_i || timeout_hit);
    end

    // Loader FSM with all outputs registered; strobes default low each clock.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg             <= ST_IDLE;
            target_reg            <= '0;
            count_reg             <= '0;
            table_length_reg      <= '0;
            shadow_reg            <= 32'd1;
            prescale_reg          <= '0;
            table_data_reg        <= '0;
            table_start_reg       <= 1'b0;
            table_wstb_reg        <= 1'b0;
            table_length_wstb_reg <= 1'b0;
            s_ready_reg           <= 1'b0;
            busy_reg              <= 1'b0;
            done_reg              <= 1'b0;
            err_reg               <= 2'd0;
        end else begin
            table_start_reg       <= 1'b0;
            table_wstb_reg        <= 1'b0;
            table_length_wstb_reg <= 1'b0;
            done_reg              <= 1'b0;
            if (bus.prescale_wstb_i) begin
                shadow_reg <= bus.prescale_i;
            end
            if (abort_now) begin
                // Any word accepted on this clock is deliberately dropped.
                state_reg   <= ST_IDLE;
                s_ready_reg <= 1'b0;
                busy_reg    <= 1'b0;
                err_reg     <= 2'd3;
            end else begin
                if (state_reg != ST_IDLE && bus.load_start_i) begin
                    err_reg <= 2'd2;
                end
                case (state_reg)
                    ST_IDLE: begin
                        // A start coinciding with abort_i is dropped: abort wins.
                        if (bus.load_start_i && !bus.abort_i) begin
                            if (!lines_ok) begin
                                err_reg <= 2'd1;
                            end else if (bus.seq_active_i) begin
                                err_reg <= 2'd2;
                            end else begin
                                state_reg       <= ST_START;
                                target_reg      <= target_next;
                                count_reg       <= '0;
                                prescale_reg    <= shadow_reg;
                                table_start_reg <= 1'b1;
                                busy_reg        <= 1'b1;
                                err_reg         <= 2'd0;
                            end
                        end
                    end
                    ST_START: begin
                        state_reg   <= ST_STREAM;
                        s_ready_reg <= 1'b1;
                    end
                    ST_STREAM: begin
                        if (accept) begin
                            table_data_reg <= bus.s_data_i;
                            table_wstb_reg <= 1'b1;
                            count_reg      <= count_reg + 16'd1;
                            if (count_reg + 16'd1 == target_reg) begin
                                s_ready_reg <= 1'b0;
                                state_reg   <= ST_COMMIT;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        table_length_reg      <= target_reg;
                        table_length_wstb_reg <= 1'b1;
                        state_reg             <= ST_DONE;
                    end
                    ST_DONE: begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.s_ready_o           = s_ready_reg;
    assign bus.TABLE_START_o       = table_start_reg;
    assign bus.TABLE_DATA_o        = table_data_reg;
    assign bus.TABLE_WSTB_o        = table_wstb_reg;
    assign bus.TABLE_LENGTH_o      = table_length_reg;
    assign bus.TABLE_LENGTH_WSTB_o = table_length_wstb_reg;
    assign bus.PRESCALE_o          = prescale_reg;
    assign bus.busy_o              = busy_reg;
    assign bus.done_o              = done_reg;
    assign bus.err_o               = err_reg;
endmodule

// File: tb/tb_seq_table_loader.sv
// tb_seq_table_loader: random and directed stimulus for seq_table_loader,
// checked every clock against a load-level reference model, plus literal
// expectations for the documented scenarios.
module tb_seq_table_loader;
    localparam int WPL  = 4;
    localparam int MAXL = 1024;
    localparam int TMO  = 16;

    logic clk;
    logic rst_n;
    seq_table_loader_if bus();

    seq_table_loader #(.WORDS_PER_LINE(WPL), .MAX_LINES(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A load is: accepted start, one setup clock, words until target reached,
    // one clock later the length commit, one clock later the done pulse.
    bit          m_active, m_streaming, took, kill, acc;
    int          m_tail;          // -1 streaming, 0 words complete, 1 length committed
    int          m_count, m_target, m_stall, lines;
    logic [31:0] m_shadow;
    logic        exp_ready, exp_start, exp_wstb, exp_lwstb, exp_busy, exp_done;
    logic [31:0] exp_data, exp_prescale;
    logic [15:0] exp_len;
    logic [1:0]  exp_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_streaming = 0; m_tail = -1; m_count = 0; m_target = 0; m_stall = 0;
            m_shadow = 32'd1; took = 0;
            exp_ready = 0; exp_start = 0; exp_wstb = 0; exp_lwstb = 0; exp_busy = 0; exp_done = 0;
            exp_data = 0; exp_prescale = 0; exp_len = 0; exp_err = 0;
        end else begin
            took = bus.s_valid_i && exp_ready;
            acc  = took && m_streaming && (m_tail < 0);
            exp_start = 0; exp_wstb = 0; exp_lwstb = 0; exp_done = 0;
            lines = int'(bus.load_lines_i);
            if (!m_active) begin
                if (bus.load_start_i && !bus.abort_i) begin
                    if (lines == 0 || lines > MAXL) exp_err = 1;
                    else if (bus.seq_active_i) exp_err = 2;
                    else begin
                        m_active = 1; m_streaming = 0; m_tail = -1; m_count = 0; m_stall = 0;
                        m_target = lines * WPL;
                        exp_start = 1; exp_busy = 1; exp_prescale = m_shadow; exp_err = 0;
                    end
                end
            end else if (m_tail == 1) begin
                if (bus.load_start_i) exp_err = 2;
                exp_done = 1; exp_busy = 0; m_active = 0;
            end else begin
                kill = bus.abort_i;
`ifdef SEQ_LOADER_TIMEOUT_EN
                if (m_streaming && m_tail < 0 && !acc && m_stall + 1 >= TMO) kill = 1;
`endif
                if (kill) begin
                    exp_err = 3; exp_busy = 0; exp_ready = 0; m_active = 0;
                end else begin
                    if (bus.load_start_i) exp_err = 2;
                    if (!m_streaming) begin
                        m_streaming = 1; exp_ready = 1;
                    end else if (m_tail == 0) begin
                        exp_lwstb = 1; exp_len = 16'(m_target); m_tail = 1;
                    end else if (acc) begin
                        exp_wstb = 1; exp_data = bus.s_data_i; m_count++; m_stall = 0;
                        if (m_count == m_target) begin exp_ready = 0; m_tail = 0; end
                    end else begin
                        m_stall++;
                    end
                end
            end
            if (bus.prescale_wstb_i) m_shadow = bus.prescale_i;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        chk("s_ready", 32'(bus.s_ready_o), 32'(exp_ready));
        chk("table_start", 32'(bus.TABLE_START_o), 32'(exp_start));
        chk("table_wstb", 32'(bus.TABLE_WSTB_o), 32'(exp_wstb));
        chk("table_data", bus.TABLE_DATA_o, exp_data);
        chk("length_wstb", 32'(bus.TABLE_LENGTH_WSTB_o), 32'(exp_lwstb));
        chk("table_length", 32'(bus.TABLE_LENGTH_o), 32'(exp_len));
        chk("prescale", bus.PRESCALE_o, exp_prescale);
        chk("busy", 32'(bus.busy_o), 32'(exp_busy));
        chk("done", 32'(bus.done_o), 32'(exp_done));
        chk("err", 32'(bus.err_o), 32'(exp_err));
    end

    // Event counters over the DUT outputs, for the literal expectations.
    int wstb_cnt = 0, lstb_cnt = 0, done_cnt = 0, start_cnt = 0;
    logic [15:0] last_len = 0;
    always @(negedge clk) begin
        if (bus.TABLE_WSTB_o) wstb_cnt++;
        if (bus.TABLE_START_o) start_cnt++;
        if (bus.done_o) done_cnt++;
        if (bus.TABLE_LENGTH_WSTB_o) begin lstb_cnt++; last_len = bus.TABLE_LENGTH_o; end
    end

    // Stream source: 0 idle, 1 back-to-back, 2 every other clock, 3 random.
    int vmode = 0;
    always @(negedge clk) begin
        if (took || !bus.s_valid_i) begin
            case (vmode)
                1:       bus.s_valid_i = 1'b1;
                2:       bus.s_valid_i = !bus.s_valid_i;
                3:       bus.s_valid_i = 1'($urandom_range(0, 1));
                default: bus.s_valid_i = 1'b0;
            endcase
            bus.s_data_i = $urandom;
        end
    end

    task automatic pulse_start(input int n);
        bus.load_start_i = 1'b1; bus.load_lines_i = 16'(n);
        @(negedge clk);
        bus.load_start_i = 1'b0;
    endtask

    task automatic set_shadow(input logic [31:0] v);
        bus.prescale_wstb_i = 1'b1; bus.prescale_i = v;
        @(negedge clk);
        bus.prescale_wstb_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.busy_o || m_active) && n < budget) begin @(negedge clk); n++; end
        chk("load_finished_in_budget", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
    endtask

    int bw, bl, bd, bs, seen;

    initial begin
        bus.load_start_i = 0; bus.load_lines_i = 0; bus.abort_i = 0; bus.prescale_i = 0;
        bus.prescale_wstb_i = 0; bus.s_data_i = 0; bus.s_valid_i = 0; bus.seq_active_i = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy_o), 0);
        chk("reset_s_ready", 32'(bus.s_ready_o), 0);
        chk("reset_prescale", bus.PRESCALE_o, 0);
        chk("reset_err", 32'(bus.err_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: lines=2, shadow=5, back-to-back words
        set_shadow(32'd5); vmode = 1;
        bw = wstb_cnt; bl = lstb_cnt; bd = done_cnt;
        pulse_start(2);
        chk("t1_start_strobe", 32'(bus.TABLE_START_o), 1);
        chk("t1_prescale", bus.PRESCALE_o, 5);
        chk("t1_busy", 32'(bus.busy_o), 1);
        wait_idle(100);
        chk("t1_wstb_count", 32'(wstb_cnt - bw), 8);
        chk("t1_length", 32'(last_len), 8);
        chk("t1_length_strobes", 32'(lstb_cnt - bl), 1);
        chk("t1_done", 32'(done_cnt - bd), 1);

        // 2: lines=1, valid every other clock
        vmode = 2; bw = wstb_cnt;
        pulse_start(1);
        wait_idle(100);
        chk("t2_wstb_count", 32'(wstb_cnt - bw), 4);
        chk("t2_length", 32'(last_len), 4);

        // 3: bad length, then sequencer active
        vmode = 0; bs = start_cnt; bw = wstb_cnt; bl = lstb_cnt;
        pulse_start(0);
        chk("t3_err_len", 32'(bus.err_o), 1);
        bus.seq_active_i = 1'b1;
        pulse_start(2);
        chk("t3_err_active", 32'(bus.err_o), 2);
        bus.seq_active_i = 1'b0;
        pulse_start(MAXL + 1);
        chk("t3_err_over_max", 32'(bus.err_o), 1);
        repeat (2) @(negedge clk);
        chk("t3_no_strobes", 32'(start_cnt - bs + wstb_cnt - bw + lstb_cnt - bl), 0);

        // 4: abort after 3 of 8 words, then a clean load clears err
        vmode = 1; bl = lstb_cnt; bd = done_cnt; seen = 0;
        pulse_start(2);
        for (int i = 0; i < 50 && seen < 3; i++) begin
            @(negedge clk);
            if (bus.TABLE_WSTB_o) seen++;
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("t4_err_abort", 32'(bus.err_o), 3);
        chk("t4_busy", 32'(bus.busy_o), 0);
        repeat (3) @(negedge clk);
        chk("t4_no_length", 32'(lstb_cnt - bl), 0);
        chk("t4_no_done", 32'(done_cnt - bd), 0);
        pulse_start(1);
        chk("t4_err_cleared", 32'(bus.err_o), 0);
        wait_idle(100);

        // 5: shadow write mid-table is not applied until the next start
        vmode = 3;
        pulse_start(2);
        repeat (3) @(negedge clk);
        set_shadow(32'd7);
        repeat (2) @(negedge clk);
        chk("t5_prescale_mid", bus.PRESCALE_o, 5);
        wait_idle(200);
        chk("t5_prescale_after", bus.PRESCALE_o, 5);
        pulse_start(1);
        chk("t5_prescale_next", bus.PRESCALE_o, 7);
        wait_idle(200);

        // Largest legal table
        vmode = 1; bw = wstb_cnt;
        pulse_start(MAXL);
        wait_idle(5000);
        chk("max_wstb_count", 32'(wstb_cnt - bw), 32'(MAXL * WPL));
        chk("max_length", 32'(last_len), 32'(MAXL * WPL));

        // Random traffic
        vmode = 3;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            bus.load_start_i    = ($urandom_range(0, 19) == 0);
            bus.load_lines_i    = (r == 0) ? 16'd0 : (r == 1) ? 16'(MAXL + 1) :
                                  (r == 2) ? 16'(MAXL) : (r == 3) ? 16'hFFFF :
                                  16'($urandom_range(1, 4));
            bus.abort_i         = ($urandom_range(0, 59) == 0);
            bus.seq_active_i    = ($urandom_range(0, 7) == 0);
            bus.prescale_wstb_i = ($urandom_range(0, 9) == 0);
            bus.prescale_i      = $urandom;
            @(negedge clk);
        end
        bus.load_start_i = 0; bus.abort_i = 0; bus.seq_active_i = 0; bus.prescale_wstb_i = 0;
        vmode = 1;
        wait_idle(6000);

        // Async reset in the middle of a load
        vmode = 3; bl = lstb_cnt;
        pulse_start(2);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy_o), 0);
        chk("rst_mid_s_ready", 32'(bus.s_ready_o), 0);
        chk("rst_mid_length_wstb", 32'(bus.TABLE_LENGTH_WSTB_o), 0);
        chk("rst_mid_prescale", bus.PRESCALE_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_length", 32'(lstb_cnt - bl), 0);
        pulse_start(1);
        chk("rst_shadow_default", bus.PRESCALE_o, 1);
        vmode = 1;
        wait_idle(100);

`ifdef SEQ_LOADER_TIMEOUT_EN
        // 6: stalled stream times out
        vmode = 0;
        pulse_start(1);
        repeat (TMO + 4) @(negedge clk);
        chk("t6_timeout_err", 32'(bus.err_o), 3);
        chk("t6_timeout_busy", 32'(bus.busy_o), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
